timer_counter_core: RTL

- 64-bit up-counter stage directly downstream of the counter-enable generator.
- Advances by one on each cycle where the upstream enable pulse cnt_en is high.
- Holds a 64-bit compare value and raises a sticky compare-match interrupt.
- The APB register block drives it through 32-bit half-word write strobes and reads back the counter, compare and status values.

---
 rtl/timer_counter_core.sv | 87 ++++++++
 1 files changed

// File: rtl/timer_counter_core.sv
// 64-bit timer counter with half-word register writes, a 64-bit compare value
// and a sticky compare-match interrupt status.
module timer_counter_core #(
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [63:0] CNT_RST = 64'h0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cnt_en,
  input  logic        timer_en,
  input  logic [31:0] wdata,
  input  logic        cnt_wr_lo,
  input  logic        cnt_wr_hi,
  input  logic        cmp_wr_lo,
  input  logic        cmp_wr_hi,
  input  logic        int_en,
  input  logic        int_clr,
  output logic [63:0] cnt,
  output logic [63:0] cmp,
  output logic        int_st,
  output logic        tim_int
);

  logic        timer_en_q;
  logic        timer_fall;
  logic        cnt_any_wr;
  logic        match;
  logic [63:0] cnt_inc;
  logic [31:0] cnt_lo_nxt;
  logic [31:0] cnt_hi_nxt;

  assign timer_fall = timer_en_q & ~timer_en;
  assign cnt_any_wr = cnt_wr_lo | cnt_wr_hi;
  assign cnt_inc    = cnt + 64'd1;
  assign match      = (cnt == cmp);
  assign tim_int    = int_st & int_en;

  // Each half picks its own source; a write to either half suppresses the
  // increment on both, so no carry leaks out of a freshly written half.
  always_comb begin
    cnt_lo_nxt = cnt[31:0];
    cnt_hi_nxt = cnt[63:32];
    if (cnt_wr_lo)
      cnt_lo_nxt = wdata;
    else if (timer_fall)
      cnt_lo_nxt = CNT_RST[31:0];
    else if (!cnt_any_wr && cnt_en)
      cnt_lo_nxt = cnt_inc[31:0];

    if (cnt_wr_hi)
      cnt_hi_nxt = wdata;
    else if (timer_fall)
      cnt_hi_nxt = CNT_RST[63:32];
    else if (!cnt_any_wr && cnt_en)
      cnt_hi_nxt = cnt_inc[63:32];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      timer_en_q <= 1'b0;
      cnt        <= CNT_RST;
    end else begin
      timer_en_q <= timer_en;
      cnt        <= {cnt_hi_nxt, cnt_lo_nxt};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cmp <= CMP_RST;
    end else begin
      if (cmp_wr_lo) cmp[31:0]  <= wdata;
      if (cmp_wr_hi) cmp[63:32] <= wdata;
    end
  end

  // Set has priority over clear so a clear during a standing match is ignored.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      int_st <= 1'b0;
    else if (match)
      int_st <= 1'b1;
    else if (int_clr)
      int_st <= 1'b0;
  end

endmodule
